axi_stream_ingress_decoupler: RTL and testbench

- Packet-aware isolation stage between the network ingress AXI-Stream and a user slave, sitting directly upstream of the slave verifier (verifier axis_s_* connects to this block's axis_m_*).
- On a software decouple request it isolates the slave at a packet boundary. On decouple_force, driven by the verifier's timeout_error_irq, it isolates immediately.
- While isolated it sinks and drops ingress traffic so the shared network path never backs up.
- On recouple it resynchronises to a packet boundary, so the slave never sees a partial packet start.

---
 rtl/axi_stream_ingress_decoupler.sv | 159 +++++++++++++++
 tb/tb_axi_stream_ingress_decoupler.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_ingress_decoupler.sv
// axi_stream_ingress_decoupler
//
// Packet-aware isolation stage between the network ingress AXI-Stream and a
// user slave. It sits directly upstream of the slave verifier.
//
// A software decouple request isolates the slave at a packet boundary.
// decouple_force (the verifier's timeout_error_irq) isolates it immediately.
// While isolated, ingress beats are accepted and dropped so the shared network
// path never backs up. On recouple the block waits for a packet boundary, so
// the slave never sees the start of a partial packet.
//
// Optional feature macro: AXIS_DROP_COUNT_EN adds a saturating 32-bit counter
// of dropped beats (drop_count) and its clear input (drop_count_clear).
//
// Ports:
//   aclk, areset        clock and synchronous active-high reset
//   axis_s_*            ingress stream from the network
//   axis_m_*            egress stream toward the verifier and slave
//   decouple            software isolation request (level)
//   decouple_force      immediate isolation request (level)
//   decouple_done       1 while the slave is isolated
//   drop_count          dropped-beat counter (AXIS_DROP_COUNT_EN only)
//   drop_count_clear    zeroes drop_count (AXIS_DROP_COUNT_EN only)
module axi_stream_ingress_decoupler #(
  parameter int unsigned AXIS_BUS_WIDTH  = 64,
  parameter int unsigned AXIS_DEST_WIDTH = 4,
  parameter bit          START_DECOUPLED = 1'b0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_s_tdata,
  input  logic [AXIS_DEST_WIDTH-1:0]    axis_s_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_s_tkeep,
  input  logic                          axis_s_tlast,
  input  logic                          axis_s_tvalid,
  output logic                          axis_s_tready,
  output logic [AXIS_BUS_WIDTH-1:0]     axis_m_tdata,
  output logic [AXIS_DEST_WIDTH-1:0]    axis_m_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]   axis_m_tkeep,
  output logic                          axis_m_tlast,
  output logic                          axis_m_tvalid,
  input  logic                          axis_m_tready,
  input  logic                          decouple,
  input  logic                          decouple_force,
`ifdef AXIS_DROP_COUNT_EN
  input  logic                          drop_count_clear,
  output logic [31:0]                   drop_count,
`endif
  output logic                          decouple_done
);

  typedef enum logic [1:0] {
    StPass,
    StDrain,
    StDecoupled,
    StResync
  } st_e;

  st_e  st_q, st_d;
  logic in_pkt_q, in_pkt_d;
  logic s_hs;
  logic pass_open;

  // Payload is never buffered; only valid/ready are gated.
  assign axis_m_tdata = axis_s_tdata;
  assign axis_m_tdest = axis_s_tdest;
  assign axis_m_tkeep = axis_s_tkeep;
  assign axis_m_tlast = axis_s_tlast;

  // Handshake/output gating depends only on registered state, so decouple inputs
  // never reach tready/tvalid combinationally.
  always_comb begin
    pass_open     = 1'b0;
    axis_m_tvalid = 1'b0;
    axis_s_tready = 1'b1;
    decouple_done = 1'b0;
    unique case (st_q)
      StPass, StDrain: begin
        pass_open     = 1'b1;
        axis_m_tvalid = axis_s_tvalid;
        axis_s_tready = axis_m_tready;
      end
      StDecoupled: begin
        decouple_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_hs = axis_s_tvalid & axis_s_tready;

  // Packet-position tracking on the ingress side, independent of state.
  assign in_pkt_d = s_hs ? ~axis_s_tlast : in_pkt_q;

  // Next-state priority: force > decouple > packet events.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StPass: begin
        if (decouple_force) begin
          st_d = StDecoupled;
        end else if (decouple) begin
          // Isolate now if ingress ends this cycle outside a packet (idle
          // between packets, or a tlast beat completing here); else drain.
          st_d = in_pkt_d ? StDrain : StDecoupled;
        end
      end
      StDrain: begin
        if (decouple_force) begin
          st_d = StDecoupled;
        end else if (!decouple) begin
          st_d = StPass;
        end else if (s_hs && axis_s_tlast) begin
          st_d = StDecoupled;
        end
      end
      StDecoupled: begin
        if (!decouple && !decouple_force) begin
          st_d = in_pkt_d ? StResync : StPass;
        end
      end
      StResync: begin
        if (decouple || decouple_force) begin
          st_d = StDecoupled;
        end else if (s_hs && axis_s_tlast) begin
          st_d = StPass;
        end
      end
      default: st_d = StDecoupled;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      st_q     <= START_DECOUPLED ? StDecoupled : StPass;
      in_pkt_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      in_pkt_q <= in_pkt_d;
    end
  end

`ifdef AXIS_DROP_COUNT_EN
  logic [31:0] drop_count_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      drop_count_q <= '0;
    end else if (drop_count_clear) begin
      drop_count_q <= '0;
    end else if (s_hs && !pass_open && (drop_count_q != 32'hFFFF_FFFF)) begin
      drop_count_q <= drop_count_q + 32'd1;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_axi_stream_ingress_decoupler.sv
// Self-checking bench for axi_stream_ingress_decoupler. A behavioural model of
// the isolation rules predicts valid/ready/done (and the drop counter when
// AXIS_DROP_COUNT_EN is defined) each cycle; directed scenarios add explicit
// constant expectations at the interesting points.
module tb_axi_stream_ingress_decoupler;

  localparam int unsigned W  = 64;
  localparam int unsigned DW = 4;
  localparam int unsigned KW = W / 8;

  localparam int MP = 0;  // passing
  localparam int MD = 1;  // draining toward isolation
  localparam int MX = 2;  // isolated
  localparam int MR = 3;  // waiting for a packet boundary

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [W-1:0]  s_tdata = '0;
  logic [DW-1:0] s_tdest = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          m_tready = 1'b1;
  logic          decouple = 1'b0;
  logic          decouple_force = 1'b0;
  logic          drop_count_clear = 1'b0;

  logic          s_tready, m_tvalid, m_tlast, done;
  logic [W-1:0]  m_tdata;
  logic [DW-1:0] m_tdest;
  logic [KW-1:0] m_tkeep;

  logic          sd_tready, sd_tvalid, sd_tlast, sd_done;
  logic [W-1:0]  sd_tdata;
  logic [DW-1:0] sd_tdest;
  logic [KW-1:0] sd_tkeep;

`ifdef AXIS_DROP_COUNT_EN
  logic [31:0]   drop_count, sd_drop_count;
`endif

  int total = 0;
  int bad   = 0;

  int               m_st    = MP;
  bit               m_inpkt = 1'b0;
  longint unsigned  m_cnt   = 0;

  always #5 aclk = ~aclk;

  axi_stream_ingress_decoupler #(
    .AXIS_BUS_WIDTH (W),
    .AXIS_DEST_WIDTH(DW),
    .START_DECOUPLED(1'b0)
  ) u_dut (
    .aclk            (aclk),
    .areset          (areset),
    .axis_s_tdata    (s_tdata),
    .axis_s_tdest    (s_tdest),
    .axis_s_tkeep    (s_tkeep),
    .axis_s_tlast    (s_tlast),
    .axis_s_tvalid   (s_tvalid),
    .axis_s_tready   (s_tready),
    .axis_m_tdata    (m_tdata),
    .axis_m_tdest    (m_tdest),
    .axis_m_tkeep    (m_tkeep),
    .axis_m_tlast    (m_tlast),
    .axis_m_tvalid   (m_tvalid),
    .axis_m_tready   (m_tready),
    .decouple        (decouple),
    .decouple_force  (decouple_force),
`ifdef AXIS_DROP_COUNT_EN
    .drop_count_clear(drop_count_clear),
    .drop_count      (drop_count),
`endif
    .decouple_done   (done)
  );

  axi_stream_ingress_decoupler #(
    .AXIS_BUS_WIDTH (W),
    .AXIS_DEST_WIDTH(DW),
    .START_DECOUPLED(1'b1)
  ) u_dut_sd (
    .aclk            (aclk),
    .areset          (areset),
    .axis_s_tdata    (s_tdata),
    .axis_s_tdest    (s_tdest),
    .axis_s_tkeep    (s_tkeep),
    .axis_s_tlast    (s_tlast),
    .axis_s_tvalid   (s_tvalid),
    .axis_s_tready   (sd_tready),
    .axis_m_tdata    (sd_tdata),
    .axis_m_tdest    (sd_tdest),
    .axis_m_tkeep    (sd_tkeep),
    .axis_m_tlast    (sd_tlast),
    .axis_m_tvalid   (sd_tvalid),
    .axis_m_tready   (m_tready),
    .decouple        (decouple),
    .decouple_force  (decouple_force),
`ifdef AXIS_DROP_COUNT_EN
    .drop_count_clear(drop_count_clear),
    .drop_count      (sd_drop_count),
`endif
    .decouple_done   (sd_done)
  );

  // Expected {axis_m_tvalid, axis_s_tready, decouple_done} for the main DUT.
  function automatic logic [2:0] exp_ctl();
    bit open;
    open = (m_st == MP) || (m_st == MD);
    return {open ? s_tvalid : 1'b0, open ? m_tready : 1'b1, m_st == MX};
  endfunction

  // Advance one clock, updating the model from the inputs held this cycle.
  task automatic tick();
    bit open, tr, hs, nin;
    int ns;
    open = (m_st == MP) || (m_st == MD);
    tr   = open ? m_tready : 1'b1;
    hs   = s_tvalid && tr;
    nin  = hs ? !s_tlast : m_inpkt;
    ns   = m_st;
    if (areset) begin
      ns    = MP;
      nin   = 1'b0;
      m_cnt = 0;
    end else begin
      case (m_st)
        MP: begin
          if (decouple_force) ns = MX;
          else if (decouple && !m_inpkt && !hs) ns = MX;
          else if (decouple && hs && s_tlast) ns = MX;
          else if (decouple) ns = MD;
        end
        MD: begin
          if (decouple_force) ns = MX;
          else if (!decouple) ns = MP;
          else if (hs && s_tlast) ns = MX;
        end
        MX: if (!decouple && !decouple_force) ns = nin ? MR : MP;
        default: begin
          if (decouple || decouple_force) ns = MX;
          else if (hs && s_tlast) ns = MP;
        end
      endcase
      if (drop_count_clear) m_cnt = 0;
      else if (hs && !open && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    @(posedge aclk);
    m_st    = ns;
    m_inpkt = nin;
    #1;
  endtask

  task automatic drive_beat(input bit valid, input bit last);
    s_tdata  = {$urandom, $urandom};
    s_tdest  = DW'($urandom);
    s_tkeep  = KW'($urandom);
    s_tlast  = last;
    s_tvalid = valid;
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    drive_beat(1'b0, 1'b0);
    tick();
    tick();
    areset = 1'b0;
    #1;
    total++;
    if ({m_tvalid, s_tready, done} !== 3'b010) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=010", {m_tvalid, s_tready, done});
    end
    total++;
    if (sd_done !== 1'b1) begin
      bad++;
      $display("FAIL reset_sd_done got=%b want=1", sd_done);
    end
  endtask

  task automatic test_pass_packet();
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b1, i == 3);
      total++;
      if ({m_tvalid, s_tready, done} !== 3'b110) begin
        bad++;
        $display("FAIL pass_ctl beat=%0d got=%b want=110", i, {m_tvalid, s_tready, done});
      end
      total++;
      if ({m_tdata, m_tdest, m_tkeep, m_tlast} !== {s_tdata, s_tdest, s_tkeep, s_tlast}) begin
        bad++;
        $display("FAIL pass_data beat=%0d got=%h want=%h", i,
                 {m_tdata, m_tdest, m_tkeep, m_tlast}, {s_tdata, s_tdest, s_tkeep, s_tlast});
      end
      tick();
    end
    m_tready = 1'b0;
    drive_beat(1'b1, 1'b0);
    total++;
    if (s_tready !== 1'b0) begin
      bad++;
      $display("FAIL pass_ready_mirror got=%b want=0", s_tready);
    end
    drive_beat(1'b0, 1'b0);
    m_tready = 1'b1;
  endtask

  task automatic test_decouple_drain();
    for (int i = 0; i < 4; i++) begin
      decouple = (i >= 2);
      drive_beat(1'b1, i == 3);
      total++;
      if ({m_tvalid, s_tready, done} !== exp_ctl() || m_tvalid !== 1'b1) begin
        bad++;
        $display("FAIL drain_ctl beat=%0d got=%b want=%b", i, {m_tvalid, s_tready, done},
                 exp_ctl());
      end
      tick();
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL drain_done got=%b want=1", done);
    end
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1, i == 2);
      total++;
      if ({m_tvalid, s_tready} !== 2'b01) begin
        bad++;
        $display("FAIL drain_drop beat=%0d got=%b want=01", i, {m_tvalid, s_tready});
      end
      tick();
    end
    m_tready = 1'b1;
  endtask

  task automatic test_force();
    decouple = 1'b0;
    drive_beat(1'b0, 1'b0);
    tick();
    drive_beat(1'b1, 1'b0);
    tick();
    m_tready = 1'b0;
    decouple_force = 1'b1;
    drive_beat(1'b1, 1'b0);
    total++;
    if ({m_tvalid, s_tready, done} !== exp_ctl()) begin
      bad++;
      $display("FAIL force_pre got=%b want=%b", {m_tvalid, s_tready, done}, exp_ctl());
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1, i == 2);
      total++;
      if ({m_tvalid, s_tready, done} !== 3'b011) begin
        bad++;
        $display("FAIL force_drop beat=%0d got=%b want=011", i, {m_tvalid, s_tready, done});
      end
      tick();
    end
    decouple_force = 1'b0;
    m_tready = 1'b1;
    drive_beat(1'b0, 1'b0);
    tick();
    total++;
    if ({m_tvalid, s_tready, done} !== 3'b010) begin
      bad++;
      $display("FAIL force_release got=%b want=010", {m_tvalid, s_tready, done});
    end
  endtask

  task automatic test_resync();
    decouple = 1'b1;
    drive_beat(1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) decouple = 1'b0;
      drive_beat(1'b1, i == 4);
      total++;
      if ({m_tvalid, s_tready} !== 2'b01) begin
        bad++;
        $display("FAIL resync_drop beat=%0d got=%b want=01", i, {m_tvalid, s_tready});
      end
      tick();
    end
    drive_beat(1'b1, 1'b0);
    total++;
    if ({m_tvalid, s_tready, done} !== 3'b110) begin
      bad++;
      $display("FAIL resync_next_pkt got=%b want=110", {m_tvalid, s_tready, done});
    end
    tick();
    drive_beat(1'b1, 1'b1);
    tick();
    drive_beat(1'b0, 1'b0);
  endtask

`ifdef AXIS_DROP_COUNT_EN
  task automatic test_drop_count();
    decouple = 1'b1;
    drop_count_clear = 1'b1;
    drive_beat(1'b0, 1'b0);
    tick();
    drop_count_clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_beat(1'b1, (i % 3) == 2);
      tick();
    end
    drive_beat(1'b0, 1'b0);
    total++;
    if (drop_count !== 32'd7 || 64'(drop_count) != m_cnt) begin
      bad++;
      $display("FAIL drop_count7 got=%0d want=7", drop_count);
    end
    drop_count_clear = 1'b1;
    drive_beat(1'b1, 1'b1);
    tick();
    drop_count_clear = 1'b0;
    drive_beat(1'b0, 1'b0);
    total++;
    if (drop_count !== 32'd0) begin
      bad++;
      $display("FAIL drop_clear got=%0d want=0", drop_count);
    end
    u_dut.drop_count_q = 32'hFFFF_FFFD;
    m_cnt = 64'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b1, 1'b1);
      tick();
    end
    drive_beat(1'b0, 1'b0);
    total++;
    if (drop_count !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL drop_saturate got=%h want=ffffffff", drop_count);
    end
    decouple = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(15) == 0) decouple = ~decouple;
      decouple_force   = ($urandom_range(31) == 0);
      drop_count_clear = ($urandom_range(63) == 0);
      m_tready         = ($urandom_range(3) != 0);
      drive_beat($urandom_range(3) != 0, $urandom_range(3) == 0);
      total++;
      if ({m_tvalid, s_tready, done} !== exp_ctl()) begin
        bad++;
        $display("FAIL rand_ctl cyc=%0d got=%b want=%b", c, {m_tvalid, s_tready, done},
                 exp_ctl());
      end
      total++;
      if ({m_tdata, m_tlast} !== {s_tdata, s_tlast}) begin
        bad++;
        $display("FAIL rand_data cyc=%0d got=%h want=%h", c, {m_tdata, m_tlast},
                 {s_tdata, s_tlast});
      end
`ifdef AXIS_DROP_COUNT_EN
      total++;
      if (64'(drop_count) != m_cnt) begin
        bad++;
        $display("FAIL rand_drop cyc=%0d got=%0d want=%0d", c, drop_count, m_cnt);
      end
`endif
      tick();
    end
    decouple = 1'b0;
    decouple_force = 1'b0;
    drop_count_clear = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic test_reset_start_decoupled();
    m_tready = 1'b1;
    drive_beat(1'b1, 1'b0);
    tick();
    // Mid-packet reset with decouple held so the reset state is observable.
    areset = 1'b1;
    decouple = 1'b1;
    drive_beat(1'b1, 1'b0);
    tick();
    areset = 1'b0;
    m_tready = 1'b0;
    drive_beat(1'b0, 1'b0);
    total++;
    if ({sd_tvalid, sd_tready, sd_done} !== 3'b011) begin
      bad++;
      $display("FAIL sd_reset_state got=%b want=011", {sd_tvalid, sd_tready, sd_done});
    end
    decouple = 1'b0;
    tick();
    // in_pkt cleared by reset, so recouple goes straight to passing.
    drive_beat(1'b1, 1'b0);
    total++;
    if ({sd_tvalid, sd_tready, sd_done} !== 3'b100) begin
      bad++;
      $display("FAIL sd_recouple got=%b want=100", {sd_tvalid, sd_tready, sd_done});
    end
    total++;
    if ({m_tvalid, s_tready, done} !== exp_ctl()) begin
      bad++;
      $display("FAIL sd_main_ctl got=%b want=%b", {m_tvalid, s_tready, done}, exp_ctl());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_pass_packet();
    test_decouple_drain();
    test_force();
    test_resync();
`ifdef AXIS_DROP_COUNT_EN
    test_drop_count();
`endif
    test_random();
    test_reset_start_decoupled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
